// File: rtl/filter_pkg.sv
// Shared state encoding and default sizing for the time-shared input filter.
// The irq feature in filter_scheduler is enabled with the FLT_IRQ_EN macro.
package filter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int DEFAULT_NCH   = 4;
  localparam int DEFAULT_DEPTH = 3;

endpackage

// File: rtl/filter_engine.sv
// Combinational agreement/hysteresis step for one channel: shift in a sample,
// then force the output high/low only when the whole history agrees.
module filter_engine
  import filter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic [DEPTH-1:0] i_histOld,
  input  logic             i_bitIn,
  input  logic             i_outOld,
  output logic [DEPTH-1:0] o_histNew,
  output logic             o_outNew,
  output logic             o_changed
);

  logic w_all1;
  logic w_all0;

  // The cast drops the oldest sample and also covers DEPTH == 1.
  assign o_histNew = DEPTH'({i_histOld, i_bitIn});
  assign w_all1    = &o_histNew;
  assign w_all0    = ~|o_histNew;

  always_comb begin
    o_outNew = i_outOld;
    if (w_all1) begin
      o_outNew = 1'b1;
    end else if (w_all0) begin
      o_outNew = 1'b0;
    end
  end

  assign o_changed = (o_outNew != i_outOld);

endmodule

// File: rtl/filter_scheduler.sv
// Round-robin scheduler sharing one filter_engine across NCH channels.
// Optional FLT_IRQ_EN adds i_irq_clr and a sticky change interrupt on o_irq.
module filter_scheduler
  import filter_pkg::*;
#(
  parameter  int NCH   = DEFAULT_NCH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = $clog2(NCH)
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_tick,
  input  logic [NCH-1:0] i_sig_in,
`ifdef FLT_IRQ_EN
  input  logic           i_irq_clr,
`endif
  output logic [NCH-1:0] o_sig_out,
  output logic           o_busy,
  output logic           o_chg_valid,
  output logic [CW-1:0]  o_chg_ch,
  output logic           o_overrun,
  output logic           o_irq
);

  state_e           r_state;
  state_e           w_nextState;
  logic [CW-1:0]    r_ch;
  logic [NCH-1:0]   r_snap;
  logic             r_pend;
  logic [NCH-1:0]   r_pendSnap;
  logic [DEPTH-1:0] r_hist [NCH];
  logic [NCH-1:0]   r_sigOut;
  logic             r_chgValid;
  logic [CW-1:0]    r_chgCh;
  logic             r_overrun;

  logic             w_scan;
  logic             w_startSweep;
  logic             w_lastCh;
  logic [DEPTH-1:0] w_histNew;
  logic             w_outNew;
  logic             w_changed;

  assign w_lastCh = (r_ch == CW'(NCH - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A queued tick at the last channel keeps us in SCAN so there is no idle gap.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_tick) w_nextState = SCAN;
      SCAN:    if (w_lastCh && !r_pend) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_scan       = (r_state == SCAN);
    w_startSweep = (r_state == IDLE) && i_tick;
  end

  filter_engine #(
    .DEPTH (DEPTH)
  ) u_engine (
    .i_histOld (r_hist[r_ch]),
    .i_bitIn   (r_snap[r_ch]),
    .i_outOld  (r_sigOut[r_ch]),
    .o_histNew (w_histNew),
    .o_outNew  (w_outNew),
    .o_changed (w_changed)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ch       <= '0;
      r_snap     <= '0;
      r_pend     <= 1'b0;
      r_pendSnap <= '0;
      r_sigOut   <= '0;
      r_chgValid <= 1'b0;
      r_chgCh    <= '0;
      r_overrun  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      r_chgValid <= 1'b0;
      if (w_startSweep) begin
        r_snap <= i_sig_in;
        r_ch   <= '0;
      end
      if (w_scan) begin
        r_hist[r_ch]   <= w_histNew;
        r_sigOut[r_ch] <= w_outNew;
        if (w_changed) begin
          r_chgValid <= 1'b1;
          r_chgCh    <= r_ch;
        end
        if (w_lastCh) begin
          r_ch <= '0;
          if (r_pend) begin
            r_snap <= r_pendSnap;
            r_pend <= 1'b0;
          end
        end else begin
          r_ch <= r_ch + 1'b1;
        end
        // Only one tick can wait behind the running sweep; any further one is lost.
        if (i_tick) begin
          if (!r_pend) begin
            r_pend     <= 1'b1;
            r_pendSnap <= i_sig_in;
          end else begin
            r_overrun <= 1'b1;
          end
        end
      end
    end
  end

`ifdef FLT_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_irq <= 1'b0;
    end else if (w_scan && w_changed) begin
      r_irq <= 1'b1;
    end else if (i_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

  assign o_sig_out   = r_sigOut;
  assign o_busy      = w_scan;
  assign o_chg_valid = r_chgValid;
  assign o_chg_ch    = r_chgCh;
  assign o_overrun   = r_overrun;

endmodule
